// File: rtl/adder_pkg.sv
// adder_pkg: shared configuration helpers for the pipelined adder
package adder_pkg;
  function automatic int stages(input int width, input int seg);
    return width / seg;
  endfunction
  function automatic bit cfg_ok(input int width, input int seg);
    return seg > 0 && width >= seg && width % seg == 0;
  endfunction
endpackage

// File: rtl/adder_seg.sv
// adder_seg: combinational SEG-bit slice of the carry chain
module adder_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_s,
  input  logic [SEG-1:0] b_s,
  input  logic           c_i,
  output logic [SEG-1:0] s_s,
  output logic           c_o,
  output logic           c_msb
);
  always_comb begin
    {c_o, s_s} = {1'b0, a_s} + {1'b0, b_s} + {{SEG{1'b0}}, c_i};
    c_msb = s_s[SEG-1] ^ a_s[SEG-1] ^ b_s[SEG-1];
  end
endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/subtract, one SEG-bit carry slice per stage, valid/ready handshake
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = stages(WIDTH, SEG);
  if (!cfg_ok(WIDTH, SEG)) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be a positive multiple of SEG");
  end
  logic             adv;
  logic             c0;
  logic [WIDTH-1:0] bp;
  logic             ovf_r;
  // x holds finished low sum slices with the not-yet-added slices of a above them
  logic             v    [STAGES];
  logic [WIDTH-1:0] x    [STAGES];
  logic [WIDTH-1:0] y    [STAGES];
  logic             c    [STAGES];
  logic [SEG-1:0]   s_w  [STAGES];
  logic             co_w [STAGES];
  logic             cm_w [STAGES];
  always_comb begin
    adv = !out_valid || out_ready;
    bp  = sub ? ~b : b;
    c0  = sub | cin;
  end
  assign in_ready  = adv;
  assign out_valid = v[STAGES-1];
  assign sum       = x[STAGES-1];
  assign cout      = c[STAGES-1];
  assign ovf       = ovf_r;
  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    if (k == 0) begin : g_first
      adder_seg #(.SEG(SEG)) u_seg (
        .a_s(a[SEG-1:0]), .b_s(bp[SEG-1:0]), .c_i(c0),
        .s_s(s_w[k]), .c_o(co_w[k]), .c_msb(cm_w[k])
      );
    end else begin : g_next
      adder_seg #(.SEG(SEG)) u_seg (
        .a_s(x[k-1][k*SEG +: SEG]), .b_s(y[k-1][k*SEG +: SEG]), .c_i(c[k-1]),
        .s_s(s_w[k]), .c_o(co_w[k]), .c_msb(cm_w[k])
      );
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        v[i] <= 1'b0;
        x[i] <= '0;
        y[i] <= '0;
        c[i] <= 1'b0;
      end
      ovf_r <= 1'b0;
    end else if (adv) begin
      v[0] <= in_valid;
      x[0] <= a;
      x[0][SEG-1:0] <= s_w[0];
      y[0] <= bp;
      c[0] <= co_w[0];
      for (int i = 1; i < STAGES; i++) begin
        v[i] <= v[i-1];
        x[i] <= x[i-1];
        x[i][i*SEG +: SEG] <= s_w[i];
        y[i] <= y[i-1];
        c[i] <= co_w[i];
      end
      ovf_r <= co_w[STAGES-1] ^ cm_w[STAGES-1];
    end
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: scoreboard bench for adder_pipe (16/4 directed+random, plus a width sweep)
module tb_adder_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic srst = 1'b1;
  always #5 clk = ~clk;
  int ncmp = 0;
  int nerr = 0;
  int n_out = 0;
  logic rnd = 1'b0;
  // reference: {ovf, cout, sum} of a + b' + c0 at width w, sum zero-extended to 32 bits
  function automatic logic [33:0] model(input int w, input logic [31:0] va, input logic [31:0] vb,
                                        input logic vc, input logic vs);
    logic [63:0] m, bq, t;
    logic ov;
    m  = (64'd1 << w) - 64'd1;
    bq = (vs ? ~{32'd0, vb} : {32'd0, vb}) & m;
    t  = ({32'd0, va} & m) + bq + {63'd0, vs | vc};
    ov = (va[w-1] == bq[w-1]) && (t[w-1] != va[w-1]);
    return {ov, t[w], t[31:0] & m[31:0]};
  endfunction
  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;
  logic [33:0] exp_q[$];
  adder_pipe #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        ncmp++;
        nerr++;
        $display("FAIL main_extra: output sum=%h with nothing outstanding", sum);
      end else check("main_result", {ovf, cout, 16'd0, sum}, exp_q.pop_front());
    end
  task automatic step(input logic vv, input logic [15:0] va, input logic [15:0] vb,
                      input logic vc, input logic vs, input logic vr, output logic acc);
    @(posedge clk);
    #1;
    in_valid = vv; a = va; b = vb; cin = vc; sub = vs; out_ready = vr;
    #1;
    acc = vv && in_ready;
    if (acc) exp_q.push_back(model(16, {16'd0, va}, {16'd0, vb}, vc, vs));
  endtask
  task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vc, input logic vs);
    logic acc;
    int t;
    t = 0;
    do begin
      step(1'b1, va, vb, vc, vs, rnd ? 1'($urandom) : 1'b1, acc);
      t++;
    end while (!acc && t < 100);
    if (!acc) begin
      ncmp++;
      nerr++;
      $display("FAIL main_issue_timeout: beat not accepted in %0d cycles", t);
    end
  endtask
  task automatic drain();
    logic acc;
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, acc);
      t++;
    end
    check("main_drain_left", 34'(exp_q.size()), 34'd0);
    repeat (6) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, acc);
  endtask
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int W = g == 0 ? 4 : g == 1 ? 8 : 32;
    localparam int S = g == 0 ? 4 : g == 1 ? 2 : 8;
    logic         iv, ir, c, s, ov, r, co, of, done;
    logic [W-1:0] av, bv, sm;
    logic [33:0]  q[$];
    adder_pipe #(.WIDTH(W), .SEG(S)) dut (
      .clk(clk), .rst(srst), .in_valid(iv), .in_ready(ir), .a(av), .b(bv),
      .cin(c), .sub(s), .out_valid(ov), .out_ready(r),
      .sum(sm), .cout(co), .ovf(of)
    );
    always @(negedge clk)
      if (!srst && ov && r) begin
        if (q.size() == 0) begin
          ncmp++;
          nerr++;
          $display("FAIL sweep_w%0d_extra: output sum=%h with nothing outstanding", W, sm);
        end else check($sformatf("sweep_w%0d_result", W), {of, co, 32'(sm)}, q.pop_front());
      end
    initial begin
      int n, t;
      done = 1'b0; iv = 1'b0; av = '0; bv = '0; c = 1'b0; s = 1'b0; r = 1'b1;
      n = 0;
      t = 0;
      @(negedge srst);
      while (n < 1000 && t < 20000) begin
        @(posedge clk);
        #1;
        iv = 1'($urandom); av = W'($urandom); bv = W'($urandom);
        c = 1'($urandom); s = 1'($urandom); r = ($urandom % 4) != 0;
        #1;
        if (iv && ir) begin
          q.push_back(model(W, 32'(av), 32'(bv), c, s));
          n++;
        end
        t++;
      end
      t = 0;
      while ((q.size() != 0 || t < 8) && t < 200) begin
        @(posedge clk);
        #1;
        iv = 1'b0; r = 1'b1;
        t++;
      end
      check($sformatf("sweep_w%0d_drain_left", W), 34'(q.size()), 34'd0);
      check($sformatf("sweep_w%0d_beats", W), 34'(n), 34'd1000);
      done = 1'b1;
    end
  end
  initial begin
    #12 srst = 1'b0;
  end
  initial begin
    logic acc, r;
    int lat, i, s, n0, t;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #12;
    check("reset_state", 34'({out_valid, cout, ovf, in_ready, sum}), 34'({4'b0001, 16'h0}));
    rst = 1'b0;
    step(1'b1, 16'd3, 16'd2, 1'b1, 1'b0, 1'b1, acc);
    lat = 0;
    do begin
      step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, acc);
      lat++;
    end while (!out_valid && lat < 10);
    check("latency", 34'(lat), 34'd4);
    check("first_sum", 34'({ovf, cout, sum}), 34'({2'b00, 16'h0006}));
    drain();
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    issue(16'h0005, 16'h0007, 1'b1, 1'b1);
    issue(16'h8000, 16'h0001, 1'b0, 1'b1);
    drain();
    n0 = n_out;
    i = 0;
    s = 0;
    while (i < 8 && s < 40) begin
      r = !(s >= 4 && s < 7);
      step(1'b1, 16'(i), 16'(i << 4), 1'b0, 1'b0, r, acc);
      if (!r) check("stall_in_ready", 34'({out_valid, in_ready}), 34'b10);
      if (acc) i++;
      s++;
    end
    drain();
    check("stream_count", 34'(n_out - n0), 34'd8);
    for (int k = 0; k < 3; k++) issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, acc);
    check("pre_reset_valid", 34'(out_valid), 34'd1);
    rst = 1'b1;
    #1;
    check("mid_reset_state", 34'({out_valid, cout, ovf, in_ready, sum}), 34'({4'b0001, 16'h0}));
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    n0 = n_out;
    issue(16'd12, 16'd1, 1'b0, 1'b0);
    drain();
    check("post_reset_count", 34'(n_out - n0), 34'd1);
    rnd = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom % 4 == 0) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'($urandom), acc);
      issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    rnd = 1'b0;
    drain();
    t = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && t < 40000) begin
      @(posedge clk);
      t++;
    end
    check("sweep_finished", 34'({g_sw[0].done, g_sw[1].done, g_sw[2].done}), 34'b111);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
